// File: rtl/klein_pkg.sv
// -----------------------------------------------------------------------------
// klein_pkg
// Shared types and constants for the KLEIN-64 two-requester arbiter.
//   klein_state_e     : sequencer states (IDLE, START, BUSY, RESP)
//   KLEIN_BLOCK_W     : block/key width in bits
//   KLEIN_CORE_LAT    : core load-to-done latency in cycles
//   KLEIN_TIMEOUT_DEF : default BUSY-state cycle limit (timeout build only)
// -----------------------------------------------------------------------------
package klein_pkg;

  localparam int KLEIN_BLOCK_W     = 64;
  localparam int KLEIN_CORE_LAT    = 12;
  localparam int KLEIN_TIMEOUT_DEF = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } klein_state_e;

endpackage

// File: rtl/klein_rr_arbiter.sv
// -----------------------------------------------------------------------------
// klein_rr_arbiter
// Two-way round-robin grant logic (purely combinational).
//   i_valid0/1 : requester N has a job
//   i_en       : grants may be issued (sequencer idle)
//   i_last     : id of the requester served last
//   o_grant    : one-hot grant, bit N = requester N
//   o_owner    : id of the granted requester (0 when nothing is granted)
// -----------------------------------------------------------------------------
module klein_rr_arbiter (
  input  logic       i_valid0,
  input  logic       i_valid1,
  input  logic       i_en,
  input  logic       i_last,
  output logic [1:0] o_grant,
  output logic       o_owner
);

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case ({i_valid1, i_valid0})
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        // Contention: the requester that was not served last wins.
        2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  assign o_owner = o_grant[1];

endmodule

// File: rtl/klein_arbiter.sv
// -----------------------------------------------------------------------------
// klein_arbiter
// Round-robin arbiter and sequencer sharing one KLEIN-64 core between two
// requesters. A granted job is registered, the core is started with a single
// pulse, the result is captured on core completion and handed back to the
// owning requester. No job is accepted until the previous one has returned.
//
// Handshakes: a transfer happens on a rising clock edge where both valid and
// ready are high. Requesters hold valid and payload until they see ready;
// dropping valid earlier is allowed and transfers nothing. On the response
// side the arbiter holds ores valid/block/err stable until ires ready.
//
// Optional feature: define KLEIN_ARB_TIMEOUT_EN to abort a job that stays in
// BUSY for TIMEOUT cycles; the owner then gets ores_err = 1 and a zero block.
// Without the macro BUSY waits for the core indefinitely and ores_err is 0.
//
// Ports:
//   iclk, ireset                  clock, synchronous active-high reset
//   ireqN_valid/_block/_key       job request from requester N
//   oreqN_ready                   job from requester N accepted this cycle
//   oresN_valid/_block/_err       result for requester N
//   iresN_ready                   requester N consumes the result
//   ocore_start                   one-cycle core start pulse
//   ocore_block, ocore_key        registered job operands
//   icore_ready, icore_block      core done flag and ciphertext
//   odbg_state                    current sequencer state
// -----------------------------------------------------------------------------
module klein_arbiter
  import klein_pkg::*;
#(
  parameter int unsigned TIMEOUT = KLEIN_TIMEOUT_DEF
) (
  input  logic                     iclk,
  input  logic                     ireset,
  input  logic                     ireq0_valid,
  input  logic                     ireq1_valid,
  output logic                     oreq0_ready,
  output logic                     oreq1_ready,
  input  logic [0:KLEIN_BLOCK_W-1] ireq0_block,
  input  logic [0:KLEIN_BLOCK_W-1] ireq1_block,
  input  logic [0:KLEIN_BLOCK_W-1] ireq0_key,
  input  logic [0:KLEIN_BLOCK_W-1] ireq1_key,
  output logic                     ores0_valid,
  output logic                     ores1_valid,
  input  logic                     ires0_ready,
  input  logic                     ires1_ready,
  output logic [0:KLEIN_BLOCK_W-1] ores0_block,
  output logic [0:KLEIN_BLOCK_W-1] ores1_block,
  output logic                     ores0_err,
  output logic                     ores1_err,
  output logic                     ocore_start,
  output logic [0:KLEIN_BLOCK_W-1] ocore_block,
  output logic [0:KLEIN_BLOCK_W-1] ocore_key,
  input  logic                     icore_ready,
  input  logic [0:KLEIN_BLOCK_W-1] icore_block,
  output klein_state_e             odbg_state
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("klein_arbiter: TIMEOUT must be in 1..255");
  end

  klein_state_e             r_state;
  klein_state_e             w_next;
  logic                     r_last;
  logic                     r_owner;
  logic [0:KLEIN_BLOCK_W-1] r_blk;
  logic [0:KLEIN_BLOCK_W-1] r_key;
  logic [0:KLEIN_BLOCK_W-1] r_res;
  logic [1:0]               w_grant;
  logic                     w_owner;
  logic                     w_accept;
  logic                     w_res_take;
  logic                     w_in_resp;
  logic                     w_timeout;

  klein_rr_arbiter u_rr (
    .i_valid0 (ireq0_valid),
    .i_valid1 (ireq1_valid),
    .i_en     (r_state == ST_IDLE),
    .i_last   (r_last),
    .o_grant  (w_grant),
    .o_owner  (w_owner)
  );

  // A grant is only issued to a valid requester, so any grant is an accept.
  assign w_accept   = |w_grant;
  assign w_in_resp  = (r_state == ST_RESP);
  assign w_res_take = w_in_resp && (r_owner ? ires1_ready : ires0_ready);

  // State register.
  always_ff @(posedge iclk) begin
    if (ireset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_START;
      ST_START: w_next = ST_BUSY;
      ST_BUSY:  if (icore_ready || w_timeout) w_next = ST_RESP;
      ST_RESP:  if (w_res_take) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operand, result and round-robin pointer registers.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_blk   <= '0;
      r_key   <= '0;
      r_res   <= '0;
    end else begin
      if (w_accept) begin
        r_owner <= w_owner;
        r_blk   <= w_owner ? ireq1_block : ireq0_block;
        r_key   <= w_owner ? ireq1_key   : ireq0_key;
      end
      if ((r_state == ST_BUSY) && icore_ready) r_res <= icore_block;
      else if (w_timeout)                      r_res <= '0;
      if (w_res_take) r_last <= r_owner;
    end
  end

  assign oreq0_ready = w_grant[0];
  assign oreq1_ready = w_grant[1];
  assign ocore_start = (r_state == ST_START);
  assign ocore_block = r_blk;
  assign ocore_key   = r_key;
  assign ores0_valid = w_in_resp & ~r_owner;
  assign ores1_valid = w_in_resp &  r_owner;
  assign ores0_block = ores0_valid ? r_res : '0;
  assign ores1_block = ores1_valid ? r_res : '0;
  assign odbg_state  = r_state;

`ifdef KLEIN_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;
  logic       r_err;

  // Clearing in START is the same as clearing on entry to BUSY; the counter
  // then holds the number of BUSY cycles already spent.
  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_START)     r_cnt <= '0;
      else if (r_state == ST_BUSY) r_cnt <= r_cnt + 8'd1;
      if (r_state == ST_BUSY) begin
        if (icore_ready)    r_err <= 1'b0;
        else if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  assign w_timeout = (r_state == ST_BUSY) && !icore_ready && (r_cnt == TO_LAST);
  assign ores0_err = ores0_valid & r_err;
  assign ores1_err = ores1_valid & r_err;
`else
  assign w_timeout = 1'b0;
  assign ores0_err = 1'b0;
  assign ores1_err = 1'b0;
`endif

endmodule

// File: tb/tb_klein_arbiter.sv
// -----------------------------------------------------------------------------
// tb_klein_arbiter
// Bench for klein_arbiter with a behavioural KLEIN-64 core stub (fixed
// 12-cycle latency, known answers for the two reference vectors).
// Build with or without KLEIN_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_klein_arbiter;
  import klein_pkg::*;

  localparam logic [0:63] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [0:63] KAT0 = 64'hCDC0_B51F_1472_2BBE;  // key 0, block FF..FF
  localparam logic [0:63] KAT1 = 64'h6456_764E_8602_E154;  // key FF..FF, block 0

  typedef struct {
    logic v0; logic v1; logic ptr; logic r0; logic r1;
  } arb_vec_t;

  typedef struct {
    logic [0:63] blk; logic [0:63] key;
  } job_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        ireset;
  logic        ireq0_valid, ireq1_valid, oreq0_ready, oreq1_ready;
  logic [0:63] ireq0_block, ireq1_block, ireq0_key, ireq1_key;
  logic        ores0_valid, ores1_valid, ires0_ready, ires1_ready;
  logic [0:63] ores0_block, ores1_block;
  logic        ores0_err, ores1_err, ocore_start;
  logic [0:63] ocore_block, ocore_key;
  logic        icore_ready;
  logic [0:63] icore_block;
  klein_state_e odbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  klein_arbiter #(.TIMEOUT(31)) dut (
    .iclk(clk), .ireset(ireset),
    .ireq0_valid(ireq0_valid), .ireq1_valid(ireq1_valid),
    .oreq0_ready(oreq0_ready), .oreq1_ready(oreq1_ready),
    .ireq0_block(ireq0_block), .ireq1_block(ireq1_block),
    .ireq0_key(ireq0_key), .ireq1_key(ireq1_key),
    .ores0_valid(ores0_valid), .ores1_valid(ores1_valid),
    .ires0_ready(ires0_ready), .ires1_ready(ires1_ready),
    .ores0_block(ores0_block), .ores1_block(ores1_block),
    .ores0_err(ores0_err), .ores1_err(ores1_err),
    .ocore_start(ocore_start), .ocore_block(ocore_block), .ocore_key(ocore_key),
    .icore_ready(icore_ready), .icore_block(icore_block),
    .odbg_state(odbg_state)
  );

  // ---------------- core stub ----------------
  function automatic logic [0:63] core_fn(input logic [0:63] b, input logic [0:63] k);
    if (k == 64'h0 && b == ALL1) return KAT0;
    if (k == ALL1 && b == 64'h0) return KAT1;
    return b ^ {k[32:63], k[0:31]} ^ 64'h5A5A_0F0F_3C3C_9696;
  endfunction

  bit          stub_hang;
  int          stub_cnt;
  logic [0:63] stub_blk, stub_key;

  always @(posedge clk) begin
    if (ireset) begin
      icore_ready <= 1'b0;
      icore_block <= '0;
      stub_cnt    <= 0;
    end else if (ocore_start) begin
      icore_ready <= 1'b0;
      stub_cnt    <= KLEIN_CORE_LAT;
      stub_blk    <= ocore_block;
      stub_key    <= ocore_key;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1 && !stub_hang) begin
        icore_ready <= 1'b1;
        icore_block <= core_fn(stub_blk, stub_key);
      end
    end
  end

  // ---------------- monitor (records events, mid-cycle) ----------------
  logic        grant_q[$];
  logic [65:0] res_q[$];
  int          n_starts, n_both_ready, n_nonowner_bad, n_resv_cycles;

  always @(negedge clk) begin
    if (!ireset) begin
      if (ocore_start) n_starts++;
      if (oreq0_ready & ireq0_valid) grant_q.push_back(1'b0);
      if (oreq1_ready & ireq1_valid) grant_q.push_back(1'b1);
      if (oreq0_ready & oreq1_ready) n_both_ready++;
      if (ores0_valid | ores1_valid) n_resv_cycles++;
      if (ores0_valid & ores1_valid) n_nonowner_bad++;
      if (!ores0_valid && (ores0_block != '0 || ores0_err)) n_nonowner_bad++;
      if (!ores1_valid && (ores1_block != '0 || ores1_err)) n_nonowner_bad++;
      if (ores0_valid & ires0_ready) res_q.push_back({1'b0, ores0_err, ores0_block});
      if (ores1_valid & ires1_ready) res_q.push_back({1'b1, ores1_err, ores1_block});
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          res_idx  = 0;
  logic [65:0] exp_q[$];
  job_t        jq0[$], jq1[$];
  arb_vec_t    tbl[8];

  function automatic logic [65:0] mk_exp(input logic req, input logic err, input logic [0:63] b);
    return {req, err, b};
  endfunction

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_results(input string tag);
    logic [65:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (res_idx < res_q.size()) check(tag, res_q[res_idx], e);
      else                        check({tag, "_count"}, res_q.size(), res_idx + 1);
      res_idx++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input logic req, input int bound, output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    while (!ok && edges < bound) begin
      tick();
      edges++;
      if (req ? ores1_valid : ores0_valid) ok = 1'b1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {odbg_state, ocore_start, ores0_valid, ores1_valid, ores0_err, ores1_err},
          {ST_IDLE, 5'b0});
    check({tag, "_cblk"}, ocore_block, 66'h0);
    check({tag, "_ckey"}, ocore_key, 66'h0);
    check({tag, "_rblk"}, {ores0_block | ores1_block}, 66'h0);
  endtask

  task automatic run_table(input logic ptr, input logic [0:63] exp_cblk);
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ptr == ptr) begin
        ireq0_valid = tbl[i].v0;
        ireq1_valid = tbl[i].v1;
        ireq0_block = 64'h0BAD_0BAD_0BAD_0BAD;
        ireq1_block = 64'h0BAD_0BAD_0BAD_0BAD;
        #2;
        check($sformatf("tbl%0d_ready", i), {oreq0_ready, oreq1_ready}, {tbl[i].r0, tbl[i].r1});
        ireq0_valid = 1'b0;
        ireq1_valid = 1'b0;
        tick();
        check($sformatf("tbl%0d_nolatch", i), {odbg_state, ocore_block}, {ST_IDLE, exp_cblk});
      end
    end
  endtask

  // Both requesters present queued jobs and consume results immediately.
  task automatic run_feed(input int max_cyc);
    int   cyc;
    bit   a0, a1;
    job_t j;
    cyc = 0;
    ires0_ready = 1'b1;
    ires1_ready = 1'b1;
    if (jq0.size() > 0) begin
      j = jq0.pop_front(); ireq0_block = j.blk; ireq0_key = j.key; ireq0_valid = 1'b1;
    end
    if (jq1.size() > 0) begin
      j = jq1.pop_front(); ireq1_block = j.blk; ireq1_key = j.key; ireq1_valid = 1'b1;
    end
    while ((ireq0_valid || ireq1_valid || odbg_state != ST_IDLE) && cyc < max_cyc) begin
      @(negedge clk);
      a0 = ireq0_valid & oreq0_ready;
      a1 = ireq1_valid & oreq1_ready;
      tick();
      cyc++;
      if (a0) begin
        if (jq0.size() > 0) begin j = jq0.pop_front(); ireq0_block = j.blk; ireq0_key = j.key; end
        else ireq0_valid = 1'b0;
      end
      if (a1) begin
        if (jq1.size() > 0) begin j = jq1.pop_front(); ireq1_block = j.blk; ireq1_key = j.key; end
        else ireq1_valid = 1'b0;
      end
    end
    check("feed_in_budget", (cyc < max_cyc), 1'b1);
    ires0_ready = 1'b0;
    ires1_ready = 1'b0;
    ireq0_valid = 1'b0;
    ireq1_valid = 1'b0;
  endtask

  // Single job on one requester, result consumed at once; checks latency.
  task automatic single_job(input string tag, input logic req, input logic [0:63] b,
                            input logic [0:63] k);
    int edges;
    bit ok;
    if (req) begin ireq1_block = b; ireq1_key = k; ireq1_valid = 1'b1; end
    else     begin ireq0_block = b; ireq0_key = k; ireq0_valid = 1'b1; end
    tick();
    ireq0_valid = 1'b0;
    ireq1_valid = 1'b0;
    check({tag, "_start"}, {odbg_state, ocore_block, ocore_key}, {ST_START, b, k});
    wait_resp(req, 60, edges, ok);
    check({tag, "_resp_seen"}, ok, 1'b1);
    check({tag, "_latency"}, edges, 14);
    exp_q.push_back(mk_exp(req, 1'b0, core_fn(b, k)));
    if (req) ires1_ready = 1'b1; else ires0_ready = 1'b1;
    tick();
    ires0_ready = 1'b0;
    ires1_ready = 1'b0;
    check({tag, "_idle"}, {odbg_state, ores0_valid, ores1_valid}, {ST_IDLE, 2'b00});
    compare_results({tag, "_res"});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          edges, s0, gbase, rv0, bad;
    bit          ok;
    logic [0:63] bb, bk;

    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    ireset = 1'b1; stub_hang = 1'b0;
    ireq0_valid = 1'b0; ireq1_valid = 1'b0; ires0_ready = 1'b0; ires1_ready = 1'b0;
    ireq0_block = '0; ireq1_block = '0; ireq0_key = '0; ireq1_key = '0;
    repeat (3) tick();
    ireset = 1'b0;
    check_reset("reset");

    // Grant table with pointer at its reset value (last served = 1).
    run_table(1'b1, 64'h0);

    // Single reference job on requester 0, counting start pulses.
    s0 = n_starts;
    ireq0_block = ALL1; ireq0_key = 64'h0; ireq0_valid = 1'b1;
    #1;
    check("t1_ready0", {oreq0_ready, oreq1_ready}, 2'b10);
    tick();
    ireq0_valid = 1'b0;
    check("t1_start", {odbg_state, ocore_start, ocore_block, ocore_key}, {ST_START, 1'b1, ALL1, 64'h0});
    wait_resp(1'b0, 60, edges, ok);
    check("t1_resp_seen", ok, 1'b1);
    check("t1_latency", edges, 14);
    check("t1_result", {ores0_err, ores1_valid, ores0_block}, {1'b0, 1'b0, KAT0});
    exp_q.push_back(mk_exp(1'b0, 1'b0, KAT0));
    ires0_ready = 1'b1;
    tick();
    ires0_ready = 1'b0;
    check("t1_idle", {odbg_state, ores0_valid}, {ST_IDLE, 1'b0});
    check("t1_one_start", n_starts - s0, 1);
    compare_results("t1_res");

    // Grant table after requester 0 was served (last served = 0).
    run_table(1'b0, ALL1);

    // Both valid in the same cycle right after reset.
    ireset = 1'b1; tick(); ireset = 1'b0;
    s0 = n_starts; gbase = grant_q.size();
    jq0.push_back('{ALL1, 64'h0});
    jq1.push_back('{64'h0, ALL1});
    exp_q.push_back(mk_exp(1'b0, 1'b0, KAT0));
    exp_q.push_back(mk_exp(1'b1, 1'b0, KAT1));
    run_feed(200);
    for (int k = 0; k < 2; k++)
      check($sformatf("both_grant%0d", k),
            (grant_q.size() > gbase + k) ? grant_q[gbase + k] : 1'bx, k[0]);
    check("both_starts", n_starts - s0, 2);
    compare_results("both_res");

    // Fairness: three jobs per requester, both holding valid.
    gbase = grant_q.size();
    for (int k = 0; k < 3; k++) begin
      jq0.push_back('{{32'h1000_0000 + 32'(k), 32'h0000_A0A0}, {32'hC0DE_0000 + 32'(k), 32'h1234_5678}});
      jq1.push_back('{{32'h2000_0000 + 32'(k), 32'h0000_B0B0}, {32'hFACE_0000 + 32'(k), 32'h8765_4321}});
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(mk_exp(1'b0, 1'b0,
        core_fn({32'h1000_0000 + 32'(k), 32'h0000_A0A0}, {32'hC0DE_0000 + 32'(k), 32'h1234_5678})));
      exp_q.push_back(mk_exp(1'b1, 1'b0,
        core_fn({32'h2000_0000 + 32'(k), 32'h0000_B0B0}, {32'hFACE_0000 + 32'(k), 32'h8765_4321})));
    end
    run_feed(400);
    for (int k = 0; k < 6; k++)
      check($sformatf("fair_grant%0d", k),
            (grant_q.size() > gbase + k) ? grant_q[gbase + k] : 1'bx, k[0]);
    compare_results("fair_res");

    // Response backpressure on requester 0 with both requesters waiting.
    bb = 64'h0123_4567_89AB_CDEF; bk = 64'h0F1E_2D3C_4B5A_6978;
    ireq0_block = bb; ireq0_key = bk; ireq0_valid = 1'b1;
    tick();
    ireq0_valid = 1'b0;
    check("bp_accept", odbg_state, ST_START);
    wait_resp(1'b0, 60, edges, ok);
    check("bp_resp_seen", ok, 1'b1);
    ireq0_block = 64'h5555_0000_5555_0000; ireq0_key = 64'h1;
    ireq1_block = 64'hAAAA_1111_AAAA_1111; ireq1_key = 64'h2;
    ireq0_valid = 1'b1; ireq1_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!ores0_valid || ores0_block !== core_fn(bb, bk) || ores0_err || oreq0_ready || oreq1_ready
          || odbg_state != ST_RESP) bad++;
      tick();
    end
    check("bp_hold_bad_cycles", bad, 0);
    exp_q.push_back(mk_exp(1'b0, 1'b0, core_fn(bb, bk)));
    ires0_ready = 1'b1;
    tick();
    ires0_ready = 1'b0;
    check("bp_next_ready", {odbg_state, oreq0_ready, oreq1_ready}, {ST_IDLE, 2'b01});
    tick();
    ireq0_valid = 1'b0; ireq1_valid = 1'b0;
    check("bp_next_accept", {odbg_state, ocore_block}, {ST_START, 64'hAAAA_1111_AAAA_1111});
    wait_resp(1'b1, 60, edges, ok);
    check("bp_next_latency", edges, 14);
    exp_q.push_back(mk_exp(1'b1, 1'b0, core_fn(64'hAAAA_1111_AAAA_1111, 64'h2)));
    ires1_ready = 1'b1;
    tick();
    ires1_ready = 1'b0;
    compare_results("bp_res");

    // Reset while BUSY: job dropped, then a fresh job completes.
    ireq0_block = 64'h7777_8888_9999_AAAA; ireq0_key = 64'h3; ireq0_valid = 1'b1;
    tick();
    ireq0_valid = 1'b0;
    repeat (5) tick();
    check("mr_in_busy", odbg_state, ST_BUSY);
    rv0 = n_resv_cycles;
    ireset = 1'b1;
    tick();
    check_reset("mr");
    ireset = 1'b0;
    repeat (30) tick();
    check("mr_no_resp", n_resv_cycles, rv0);
    single_job("mr_fresh", 1'b1, 64'h1357_9BDF_0246_8ACE, 64'hFEDC_BA98_7654_3210);

    // Core that never finishes.
    stub_hang = 1'b1;
    rv0 = n_resv_cycles;
    ireq0_block = 64'hDEAD_BEEF_0000_1111; ireq0_key = 64'h4; ireq0_valid = 1'b1;
    tick();
    ireq0_valid = 1'b0;
`ifdef KLEIN_ARB_TIMEOUT_EN
    wait_resp(1'b0, 80, edges, ok);
    check("to_resp_seen", ok, 1'b1);
    check("to_latency", edges, 32);
    check("to_result", {ores0_err, ores0_block}, {1'b1, 64'h0});
    exp_q.push_back(mk_exp(1'b0, 1'b1, 64'h0));
    ires0_ready = 1'b1;
    tick();
    ires0_ready = 1'b0;
    compare_results("to_res");
`else
    repeat (60) tick();
    check("to_stays_busy", odbg_state, ST_BUSY);
    check("to_no_resp", n_resv_cycles, rv0);
    ireset = 1'b1; tick(); ireset = 1'b0;
`endif
    stub_hang = 1'b0;
    single_job("after_hang", 1'b1, 64'h0F0F_F0F0_0F0F_F0F0, 64'h3333_CCCC_3333_CCCC);

    check("never_both_ready", n_both_ready, 0);
    check("nonowner_quiet", n_nonowner_bad, 0);
    check("no_extra_results", res_q.size(), res_idx);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
